cam_capture: RTL
================

// Module: cam_capture
// PURPOSE
// - Camera-side front end. Samples OV7670 vsync/href/8-bit data on the pixel clock.
// - Packs byte pairs into RGB565 pixels and tracks x/y position.
// - Writes each pixel into the camera->SDRAM write FIFO (valid-only, no backpressure).
// - Also produces an 8-bit grayscale pixel for the Sobel path.
// PARAMETERS
// - H_ACTIVE  640  pixels per line (2*H_ACTIVE bytes while href high)
// - V_ACTIVE  480  lines per frame
// - XW        10   x counter width
// - YW        9    y counter width
// PORTS
// - clk_i          in   1   camera pixel clock (cam_pclk); all logic on rising edge
// - rst_ni         in   1   asynchronous active-low reset
// - en_i           in   1   capture enable; high after camera config done (led_o)
// - cam_vsync_i    in   1   frame sync, high = blanking
// - cam_href_i     in   1   line valid, high = active bytes
// - cam_data_i     in   8   pixel byte, high byte first
// - fifo_full_i    in   1   downstream write FIFO full
// - pix_o          out  16  RGB565 pixel {R5,G6,B5}
// - gray_o         out  8   (R*77+G*150+B*29)>>8 on 8-bit expanded channels
// - pix_valid_o    out  1   one-cycle FIFO write strobe
// - x_o            out  XW  column of pix_o
// - y_o            out  YW  row of pix_o
// - sof_o          out  1   pulse with first pixel of frame (0,0)
// - eof_o          out  1   pulse with last pixel (H_ACTIVE-1,V_ACTIVE-1)
// - err_o          out  3   sticky {overflow, bad_line, bad_frame}
// BEHAVIOUR
// - Reset values: all outputs 0; FSM in WAIT_VS.
// - Inputs are registered once; latency is 2 clk from the second byte to pix_valid_o.
// - FSM states and transitions:
//   - WAIT_VS: wait for en_i and a vsync rising edge. Drops any partial frame after enable.
//   - VS_HIGH: on vsync falling edge -> LINE_WAIT; y=0.
//   - LINE_WAIT: on href high -> BYTE_HI.
//   - BYTE_HI: latch data into hi byte -> BYTE_LO.
//   - BYTE_LO: form pixel and emit -> BYTE_HI while href is high.
//   - On href fall -> LINE_WAIT with y+1; x cleared.
// - Byte phase resets on every href rise; it never carries between lines.
// - Gray arithmetic:
//   - Channels are expanded by bit replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
//   - Products use a 16-bit sum; gray_o = sum[15:8].
//   - gray_o is aligned with pix_o.
// - Boundary conditions:
//   - Line longer than H_ACTIVE pixels: extra pixels are not emitted; set bad_line.
//   - href falls while in BYTE_LO (odd byte count): drop the half pixel; set bad_line.
//   - Line shorter than H_ACTIVE: set bad_line; the next line still starts at x=0.
//   - More than V_ACTIVE lines: extra lines are ignored.
//   - vsync rises mid-frame before V_ACTIVE lines: set bad_frame; go to VS_HIGH (resync); no eof_o.
//   - vsync rises with href high: treat as a vsync event (frame aborted, as above).
//   - pix_valid_o while fifo_full_i: the pixel is still strobed (FIFO drops it); set overflow.
//   - en_i low: return to WAIT_VS at the next clk. Outputs become quiet (valid=0); err_o holds.
//   - err_o clears only on reset or on en_i rising.
//   - rst_ni asserted mid-line: immediate clear. After release, the rest of the frame is discarded until the next vsync.
// STRUCTURE
// - Shared package cam_pkg:
//   - cap_state_e (WAIT_VS, VS_HIGH, LINE_WAIT, BYTE_HI, BYTE_LO)
//   - H_ACTIVE/V_ACTIVE constants
//   - rgb565_t packed struct
//   - ERR_* bit indices
// - One sub-module rgb565_to_gray: purely combinational, reused by the Sobel stage.
// TESTING
// - Nominal frame:
//   - Stimulus: en=1; vsync pulse; 480 lines of href = 1280 pclk, byte pattern {x[7:0], y[7:0]}.
//   - Required: exactly 307200 strobes; pix_o={x,y} at each (x,y); sof_o at (0,0); eof_o at (639,479); err_o=0.
// - Gray check:
//   - Bytes F8,00 (pure red) -> gray_o=76.
//   - FF,FF -> gray_o=255 (sum 65280).
//   - 00,00 -> 0.
// - Odd/long line:
//   - Line 5 has 1281 bytes -> 640 pixels emitted, bad_line set; line 6 starts x=0.
//   - Line 7 has 1282 bytes -> 640 pixels emitted, bad_line set.
// - Early vsync: vsync rises after 200 lines -> bad_frame set; no eof_o; next frame captured cleanly from y=0.
// - Overflow + mid-frame enable:
//   - fifo_full_i=1 for 10 pixels -> 10 strobes, overflow set.
//   - en_i rises mid-frame -> nothing emitted until the vsync after enable.
// - Reset mid-line: rst_ni low at x=300 -> outputs 0 in the same cycle; no pixels until the next full frame.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture front end and the Sobel path.
//   cap_state_e  : capture FSM states
//   CAM_H_ACTIVE : active pixels per line
//   CAM_V_ACTIVE : active lines per frame
//   rgb565_t     : packed {R5,G6,B5} pixel
//   ERR_*        : bit positions inside the sticky error vector
package cam_pkg;

  localparam int unsigned CAM_H_ACTIVE = 640;
  localparam int unsigned CAM_V_ACTIVE = 480;

  localparam int unsigned ERR_BAD_FRAME = 0;
  localparam int unsigned ERR_BAD_LINE  = 1;
  localparam int unsigned ERR_OVERFLOW  = 2;

  typedef enum logic [2:0] {
    WAIT_VS,
    VS_HIGH,
    LINE_WAIT,
    BYTE_HI,
    BYTE_LO
  } cap_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/rgb565_to_gray.sv
// Combinational RGB565 -> 8-bit luma.
// Each channel is widened to 8 bits by replicating its top bits, then
// gray = (R*77 + G*150 + B*29) >> 8 using a 16-bit sum (max 65280).
//   pix_i  : RGB565 pixel
//   gray_o : 8-bit grayscale value
module rgb565_to_gray
  import cam_pkg::*;
(
  input  rgb565_t    pix_i,
  output logic [7:0] gray_o
);

  logic [7:0]  w_r8;
  logic [7:0]  w_g8;
  logic [7:0]  w_b8;
  logic [15:0] w_sum;

  assign w_r8  = {pix_i.r, pix_i.r[4:2]};
  assign w_g8  = {pix_i.g, pix_i.g[5:4]};
  assign w_b8  = {pix_i.b, pix_i.b[4:2]};
  assign w_sum = w_r8 * 16'd77 + w_g8 * 16'd150 + w_b8 * 16'd29;

  assign gray_o = w_sum[15:8];

endmodule

// File: rtl/cam_capture.sv
// OV7670 capture front end. Samples vsync/href/data on the pixel clock,
// packs byte pairs (high byte first) into RGB565 pixels, tracks x/y and
// strobes each pixel towards the SDRAM write FIFO together with its gray value.
//   clk_i, rst_ni         : pixel clock, async active-low reset
//   en_i                  : capture enable (rising edge clears err_o)
//   cam_vsync_i/href_i    : frame sync (high = blanking) / line valid
//   cam_data_i            : pixel byte
//   fifo_full_i           : downstream FIFO full (no backpressure, flags overflow)
//   pix_o, gray_o         : RGB565 pixel and its 8-bit luma
//   pix_valid_o           : one-cycle write strobe
//   x_o, y_o              : position of pix_o
//   sof_o, eof_o          : first / last pixel of a complete frame
//   err_o                 : sticky {overflow, bad_line, bad_frame}
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = CAM_H_ACTIVE,
  parameter int unsigned V_ACTIVE = CAM_V_ACTIVE,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9
)(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          cam_vsync_i,
  input  logic          cam_href_i,
  input  logic [7:0]    cam_data_i,
  input  logic          fifo_full_i,
  output logic [15:0]   pix_o,
  output logic [7:0]    gray_o,
  output logic          pix_valid_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          sof_o,
  output logic          eof_o,
  output logic [2:0]    err_o
);

  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic          r_vs;
  logic          r_vs_q;
  logic          r_href;
  logic [7:0]    r_data;
  logic          r_en_q;
  logic [7:0]    r_hi;
  cap_state_e    r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_long;

  logic          w_vs_rise;
  logic          w_vs_fall;
  logic          w_en_rise;
  logic          w_in_frame;
  rgb565_t       w_pix;
  logic [7:0]    w_gray;

  // Input sampling stage; vsync gets a second flop for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vs   <= 1'b0;
      r_vs_q <= 1'b0;
      r_href <= 1'b0;
      r_data <= '0;
      r_en_q <= 1'b0;
    end else begin
      r_vs   <= cam_vsync_i;
      r_vs_q <= r_vs;
      r_href <= cam_href_i;
      r_data <= cam_data_i;
      r_en_q <= en_i;
    end
  end

  assign w_vs_rise  = r_vs & ~r_vs_q;
  assign w_vs_fall  = ~r_vs & r_vs_q;
  assign w_en_rise  = en_i & ~r_en_q;
  assign w_in_frame = (r_y < Y_END);
  assign w_pix      = rgb565_t'({r_hi, r_data});

  rgb565_to_gray u_gray (
    .pix_i  (w_pix),
    .gray_o (w_gray)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= WAIT_VS;
      r_hi        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_long      <= 1'b0;
      pix_o       <= '0;
      gray_o      <= '0;
      pix_valid_o <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
      err_o       <= '0;
    end else begin
      pix_valid_o <= 1'b0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;

      // en_i can only rise after a cycle with en_i low, during which no
      // pixel was strobed, so the clear never races the overflow set.
      if (w_en_rise) begin
        err_o <= '0;
      end
      if (pix_valid_o && fifo_full_i) begin
        err_o[ERR_OVERFLOW] <= 1'b1;
      end

      if (!en_i) begin
        r_state <= WAIT_VS;
      end else begin
        case (r_state)
          WAIT_VS: begin
            if (w_vs_rise) begin
              r_state <= VS_HIGH;
            end
          end

          VS_HIGH: begin
            if (w_vs_fall) begin
              r_state <= LINE_WAIT;
              r_x     <= '0;
              r_y     <= '0;
              r_long  <= 1'b0;
            end
          end

          LINE_WAIT, BYTE_HI, BYTE_LO: begin
            if (w_vs_rise) begin
              // vsync wins even with href high; a short frame is flagged.
              if (w_in_frame) begin
                err_o[ERR_BAD_FRAME] <= 1'b1;
              end
              r_state <= VS_HIGH;
            end else if (r_state == LINE_WAIT) begin
              // The sampled byte on the first href-high cycle is already
              // the high byte, so it is latched here rather than in BYTE_HI.
              if (r_href) begin
                r_hi    <= r_data;
                r_state <= BYTE_LO;
              end
            end else if (!r_href) begin
              // End of line: short, long or odd-length lines are flagged.
              if (w_in_frame) begin
                if ((r_state == BYTE_LO) || r_long || (r_x != X_END)) begin
                  err_o[ERR_BAD_LINE] <= 1'b1;
                end
                r_y <= r_y + 1'b1;
              end
              r_x     <= '0;
              r_long  <= 1'b0;
              r_state <= LINE_WAIT;
            end else if (r_state == BYTE_HI) begin
              r_hi    <= r_data;
              r_state <= BYTE_LO;
            end else begin
              r_state <= BYTE_HI;
              if (w_in_frame) begin
                if (r_x == X_END) begin
                  r_long <= 1'b1;
                end else begin
                  pix_o       <= w_pix;
                  gray_o      <= w_gray;
                  pix_valid_o <= 1'b1;
                  x_o         <= r_x;
                  y_o         <= r_y;
                  sof_o       <= (r_x == '0) && (r_y == '0);
                  eof_o       <= (r_x == X_LAST) && (r_y == Y_LAST);
                  r_x         <= r_x + 1'b1;
                end
              end
            end
          end

          default: r_state <= WAIT_VS;
        endcase
      end
    end
  end

endmodule
